// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART TX arbiter and related schedulers.
package uart_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCK
    } arb_state_t;

    localparam int DEFAULT_DATA_WIDTH = 8;

    // Index width that stays at least one bit wide for single-entry vectors.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority encoder: returns the first set request searching upward
// (with wrap) from last+1, plus a found flag.
module rr_pick
    import uart_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] idx,
    output logic          found
);

    int cand;

    // Walk offsets from farthest to nearest so the nearest match wins.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int off = N; off >= 1; off--) begin
            cand = (int'(last) + off) % N;
            if (req[cand]) begin
                idx   = IW'(cand);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locking arbiter in front of the UART TX FIFO write port.
// Optional lock watchdog is enabled with `define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
    input  logic [NUM_REQ-1:0]            i_req_last,
    output logic [NUM_REQ-1:0]            o_req_ready,
    output logic                          o_wr_en,
    output logic [DATA_WIDTH-1:0]         o_wr_data,
    input  logic                          i_full,
    input  logic                          i_almost_full,
    output logic [NUM_REQ-1:0]            o_grant,
    output logic                          o_busy,
    output logic                          o_timeout
);

    localparam int IW = idx_width(NUM_REQ);

    arb_state_t              state;
    logic [IW-1:0]           gnt_idx;
    logic [IW-1:0]           rr_last;
    logic [IW-1:0]           pick_idx;
    logic                    pick_found;
    logic                    cur_valid;
    logic                    cur_last;
    logic [DATA_WIDTH-1:0]   cur_data;
    logic                    xfer;
    logic                    locked;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .req   (i_req_valid),
        .last  (rr_last),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign locked    = (state == ARB_LOCK);
    assign cur_valid = i_req_valid[gnt_idx];
    assign cur_last  = i_req_last[gnt_idx];
    assign cur_data  = i_req_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];

    // Only i_full stalls a locked packet; almost-full just blocks new grants.
    assign xfer        = locked & cur_valid & ~i_full;
    assign o_req_ready = xfer ? o_grant : '0;
    assign o_wr_en     = xfer;
    assign o_wr_data   = locked ? cur_data : '0;
    assign o_busy      = locked;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wd_cnt;
    logic          wd_fire;

    // Counts only cycles where the locked requester has nothing to offer.
    assign wd_fire = locked & ~cur_valid & ((int'(wd_cnt) + 1) >= TIMEOUT_CYCLES);
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign o_timeout          = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ARB_IDLE;
            gnt_idx <= '0;
            rr_last <= IW'(NUM_REQ - 1);
            o_grant <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            wd_cnt    <= '0;
            o_timeout <= 1'b0;
`endif
        end else begin
`ifdef UART_ARB_TIMEOUT_EN
            o_timeout <= 1'b0;
`endif
            case (state)
                ARB_IDLE: begin
`ifdef UART_ARB_TIMEOUT_EN
                    wd_cnt <= '0;
`endif
                    if (pick_found && !i_almost_full) begin
                        gnt_idx <= pick_idx;
                        o_grant <= NUM_REQ'(1) << pick_idx;
                        state   <= ARB_LOCK;
                    end
                end
                ARB_LOCK: begin
                    if (xfer && cur_last) begin
                        state   <= ARB_IDLE;
                        rr_last <= gnt_idx;
                        o_grant <= '0;
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    if (xfer) begin
                        wd_cnt <= '0;
                    end else if (wd_fire) begin
                        wd_cnt    <= '0;
                        o_timeout <= 1'b1;
                        state     <= ARB_IDLE;
                        rr_last   <= gnt_idx;
                        o_grant   <= '0;
                    end else if (!cur_valid) begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Table-driven bench for uart_tx_arbiter (NUM_REQ=2, DATA_WIDTH=8).
// Watchdog sequence depends on UART_ARB_TIMEOUT_EN.
module tb_uart_tx_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_last;
    logic [1:0]  req_ready;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        full;
    logic        almost_full;
    logic [1:0]  grant;
    logic        busy;
    logic        timeout;

    int compared;
    int mismatched;
    int vec_no;

    typedef struct {
        logic        rst;
        logic [1:0]  valid;
        logic [15:0] data;
        logic [1:0]  last;
        logic        full;
        logic        afull;
        logic [1:0]  ready;
        logic        wr_en;
        logic [7:0]  wr_data;
        logic [1:0]  grant;
        logic        busy;
        logic        timeout;
    } vec_t;

    vec_t vecs[$];

    uart_tx_arbiter #(
        .NUM_REQ        (2),
        .DATA_WIDTH     (8),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_req_valid   (req_valid),
        .i_req_data    (req_data),
        .i_req_last    (req_last),
        .o_req_ready   (req_ready),
        .o_wr_en       (wr_en),
        .o_wr_data     (wr_data),
        .i_full        (full),
        .i_almost_full (almost_full),
        .o_grant       (grant),
        .o_busy        (busy),
        .o_timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t row(
        input logic r, input logic [1:0] v, input logic [7:0] d1, input logic [7:0] d0,
        input logic [1:0] l, input logic f, input logic af,
        input logic [1:0] rdy, input logic we, input logic [7:0] wd,
        input logic [1:0] g, input logic b, input logic to
    );
        vec_t x;
        x.rst = r; x.valid = v; x.data = {d1, d0}; x.last = l; x.full = f; x.afull = af;
        x.ready = rdy; x.wr_en = we; x.wr_data = wd; x.grant = g; x.busy = b; x.timeout = to;
        return x;
    endfunction

    task automatic checkField(input string name, input logic [15:0] act, input logic [15:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s (vec %0d): got %0h, expected %0h", name, vec_no, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t x);
        @(negedge clk);
        rst         = x.rst;
        req_valid   = x.valid;
        req_data    = x.data;
        req_last    = x.last;
        full        = x.full;
        almost_full = x.afull;
        #1;
    endtask

    task automatic checkOutput(input vec_t x);
        checkField("ready",   16'(req_ready), 16'(x.ready));
        checkField("wr_en",   16'(wr_en),     16'(x.wr_en));
        checkField("wr_data", 16'(wr_data),   16'(x.wr_data));
        checkField("grant",   16'(grant),     16'(x.grant));
        checkField("busy",    16'(busy),      16'(x.busy));
        checkField("timeout", 16'(timeout),   16'(x.timeout));
        vec_no++;
    endtask

    task automatic runRow(input vec_t x);
        applyStimulus(x);
        checkOutput(x);
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0;
        full = 1'b0; almost_full = 1'b0;
        compared = 0; mismatched = 0; vec_no = 0;

        // Reset, idle, single requester, reset mid-packet
        vecs.push_back(row(1, 2'b00, 8'h00, 8'h00, 2'b00, 0, 0, 2'b00, 0, 8'h00, 2'b00, 0, 0));
        vecs.push_back(row(0, 2'b00, 8'h00, 8'h00, 2'b00, 0, 0, 2'b00, 0, 8'h00, 2'b00, 0, 0));
        vecs.push_back(row(0, 2'b00, 8'h00, 8'h00, 2'b00, 0, 0, 2'b00, 0, 8'h00, 2'b00, 0, 0));
        vecs.push_back(row(0, 2'b01, 8'h00, 8'hA1, 2'b00, 0, 0, 2'b00, 0, 8'h00, 2'b00, 0, 0));
        vecs.push_back(row(0, 2'b01, 8'h00, 8'hA1, 2'b00, 0, 0, 2'b01, 1, 8'hA1, 2'b01, 1, 0));
        vecs.push_back(row(0, 2'b01, 8'h00, 8'hA2, 2'b00, 0, 0, 2'b01, 1, 8'hA2, 2'b01, 1, 0));
        vecs.push_back(row(0, 2'b01, 8'h00, 8'hA3, 2'b01, 0, 0, 2'b01, 1, 8'hA3, 2'b01, 1, 0));
        vecs.push_back(row(0, 2'b00, 8'h00, 8'h00, 2'b00, 0, 0, 2'b00, 0, 8'h00, 2'b00, 0, 0));
        vecs.push_back(row(0, 2'b10, 8'h30, 8'h00, 2'b00, 0, 0, 2'b00, 0, 8'h00, 2'b00, 0, 0));
        vecs.push_back(row(0, 2'b10, 8'h30, 8'h00, 2'b00, 0, 0, 2'b10, 1, 8'h30, 2'b10, 1, 0));
        vecs.push_back(row(1, 2'b10, 8'h31, 8'h00, 2'b00, 0, 0, 2'b00, 0, 8'h00, 2'b00, 0, 0));
        vecs.push_back(row(0, 2'b00, 8'h00, 8'h00, 2'b00, 0, 0, 2'b00, 0, 8'h00, 2'b00, 0, 0));
        // Contention: req0 first after reset, one gap cycle, then req1
        vecs.push_back(row(0, 2'b11, 8'h20, 8'h10, 2'b00, 0, 0, 2'b00, 0, 8'h00, 2'b00, 0, 0));
        vecs.push_back(row(0, 2'b11, 8'h20, 8'h10, 2'b00, 0, 0, 2'b01, 1, 8'h10, 2'b01, 1, 0));
        vecs.push_back(row(0, 2'b11, 8'h20, 8'h11, 2'b01, 0, 0, 2'b01, 1, 8'h11, 2'b01, 1, 0));
        vecs.push_back(row(0, 2'b10, 8'h20, 8'h00, 2'b00, 0, 0, 2'b00, 0, 8'h00, 2'b00, 0, 0));
        vecs.push_back(row(0, 2'b10, 8'h20, 8'h00, 2'b00, 0, 0, 2'b10, 1, 8'h20, 2'b10, 1, 0));
        vecs.push_back(row(0, 2'b10, 8'h21, 8'h00, 2'b10, 0, 0, 2'b10, 1, 8'h21, 2'b10, 1, 0));
        // Single-byte packets: rotation alternates winners
        vecs.push_back(row(0, 2'b11, 8'h22, 8'h12, 2'b11, 0, 0, 2'b00, 0, 8'h00, 2'b00, 0, 0));
        vecs.push_back(row(0, 2'b11, 8'h22, 8'h12, 2'b11, 0, 0, 2'b01, 1, 8'h12, 2'b01, 1, 0));
        vecs.push_back(row(0, 2'b11, 8'h22, 8'h13, 2'b11, 0, 0, 2'b00, 0, 8'h00, 2'b00, 0, 0));
        vecs.push_back(row(0, 2'b11, 8'h22, 8'h13, 2'b11, 0, 0, 2'b10, 1, 8'h22, 2'b10, 1, 0));
        vecs.push_back(row(0, 2'b01, 8'h00, 8'h13, 2'b01, 0, 0, 2'b00, 0, 8'h00, 2'b00, 0, 0));
        vecs.push_back(row(0, 2'b01, 8'h00, 8'h13, 2'b01, 0, 0, 2'b01, 1, 8'h13, 2'b01, 1, 0));
        vecs.push_back(row(0, 2'b00, 8'h00, 8'h00, 2'b00, 0, 0, 2'b00, 0, 8'h00, 2'b00, 0, 0));
        // Full stall mid-packet; almost-full does not stall a locked packet
        vecs.push_back(row(0, 2'b01, 8'h00, 8'h40, 2'b00, 0, 0, 2'b00, 0, 8'h00, 2'b00, 0, 0));
        vecs.push_back(row(0, 2'b01, 8'h00, 8'h40, 2'b00, 0, 0, 2'b01, 1, 8'h40, 2'b01, 1, 0));
        vecs.push_back(row(0, 2'b01, 8'h00, 8'h41, 2'b00, 1, 0, 2'b00, 0, 8'h41, 2'b01, 1, 0));
        vecs.push_back(row(0, 2'b01, 8'h00, 8'h41, 2'b00, 1, 1, 2'b00, 0, 8'h41, 2'b01, 1, 0));
        vecs.push_back(row(0, 2'b01, 8'h00, 8'h41, 2'b00, 0, 1, 2'b01, 1, 8'h41, 2'b01, 1, 0));
        vecs.push_back(row(0, 2'b01, 8'h00, 8'h42, 2'b01, 0, 0, 2'b01, 1, 8'h42, 2'b01, 1, 0));
        // Almost full blocks a new grant in IDLE
        vecs.push_back(row(0, 2'b10, 8'h50, 8'h00, 2'b00, 0, 1, 2'b00, 0, 8'h00, 2'b00, 0, 0));
        vecs.push_back(row(0, 2'b10, 8'h50, 8'h00, 2'b00, 0, 1, 2'b00, 0, 8'h00, 2'b00, 0, 0));
        vecs.push_back(row(0, 2'b10, 8'h50, 8'h00, 2'b00, 0, 0, 2'b00, 0, 8'h00, 2'b00, 0, 0));
        vecs.push_back(row(0, 2'b10, 8'h50, 8'h00, 2'b10, 0, 0, 2'b10, 1, 8'h50, 2'b10, 1, 0));
        vecs.push_back(row(0, 2'b00, 8'h00, 8'h00, 2'b00, 0, 0, 2'b00, 0, 8'h00, 2'b00, 0, 0));

        foreach (vecs[i]) runRow(vecs[i]);

        // Requester 0 locks, sends one byte, then goes silent with req1 waiting
        runRow(row(0, 2'b11, 8'h70, 8'h60, 2'b00, 0, 0, 2'b00, 0, 8'h00, 2'b00, 0, 0));
        runRow(row(0, 2'b11, 8'h70, 8'h60, 2'b00, 0, 0, 2'b01, 1, 8'h60, 2'b01, 1, 0));
`ifdef UART_ARB_TIMEOUT_EN
        for (int i = 0; i < 4; i++)
            runRow(row(0, 2'b10, 8'h70, 8'h60, 2'b00, 0, 0, 2'b00, 0, 8'h60, 2'b01, 1, 0));
        runRow(row(0, 2'b10, 8'h70, 8'h60, 2'b00, 0, 0, 2'b00, 0, 8'h00, 2'b00, 0, 1));
        runRow(row(0, 2'b10, 8'h70, 8'h60, 2'b10, 0, 0, 2'b10, 1, 8'h70, 2'b10, 1, 0));
`else
        for (int i = 0; i < 10; i++)
            runRow(row(0, 2'b10, 8'h70, 8'h60, 2'b00, 0, 0, 2'b00, 0, 8'h60, 2'b01, 1, 0));
        runRow(row(0, 2'b11, 8'h70, 8'h61, 2'b01, 0, 0, 2'b01, 1, 8'h61, 2'b01, 1, 0));
        runRow(row(0, 2'b10, 8'h70, 8'h00, 2'b00, 0, 0, 2'b00, 0, 8'h00, 2'b00, 0, 0));
        runRow(row(0, 2'b10, 8'h70, 8'h00, 2'b10, 0, 0, 2'b10, 1, 8'h70, 2'b10, 1, 0));
`endif
        runRow(row(0, 2'b00, 8'h00, 8'h00, 2'b00, 0, 0, 2'b00, 0, 8'h00, 2'b00, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
